// File: rtl/mux2_4.sv
// WIDTH-bit 2:1 mux with a combinational result, an enabled registered copy and a
// saturating select-change counter. Define MUX2_4_PARITY_EN to add even-parity outputs par/par_q.
module mux2_4 #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] out,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  input  logic             en,
  output logic [WIDTH-1:0] out_q,
  output logic [CNT_W-1:0] sel_changes,
  input  logic             clr
`ifdef MUX2_4_PARITY_EN
  ,
  output logic             par,
  output logic             par_q
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] out_q_d;
  logic [CNT_W-1:0] sel_changes_q;
  logic [CNT_W-1:0] sel_changes_d;
  logic             s_prev_q;
  logic             s_prev_d;

  // Conditional operator keeps bits where a and b agree when s is unknown.
  assign out         = s ? b : a;
  assign sel_changes = sel_changes_q;

  // Next-state for the registered result and the select tracker.
  always_comb begin
    out_q_d       = out_q;
    sel_changes_d = sel_changes_q;
    s_prev_d      = s;
    if (en) begin
      out_q_d = out;
    end else begin
      out_q_d = out_q;
    end
    if (clr) begin
      sel_changes_d = {CNT_W{1'b0}};
    end else if ((s != s_prev_q) && (sel_changes_q != CNT_MAX)) begin
      sel_changes_d = sel_changes_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      sel_changes_d = sel_changes_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q         <= {WIDTH{1'b0}};
      sel_changes_q <= {CNT_W{1'b0}};
      s_prev_q      <= 1'b0;
    end else begin
      out_q         <= out_q_d;
      sel_changes_q <= sel_changes_d;
      s_prev_q      <= s_prev_d;
    end
  end

`ifdef MUX2_4_PARITY_EN
  function automatic logic even_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  logic par_q_d;

  assign par = even_parity(out);

  // Parity register follows out_q under the same enable.
  always_comb begin
    if (en) begin
      par_q_d = par;
    end else begin
      par_q_d = par_q;
    end
  end

  // Parity flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_q_d;
    end
  end
`endif

endmodule

// File: tb/tb_mux2_4.sv
// Directed self-checking bench for mux2_4: vector table for the combinational path,
// hand-written sequences for load/hold, async reset, counter saturation and clear priority.
module tb_mux2_4;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             s;
  logic             en;
  logic [WIDTH-1:0] out_q;
  logic [CNT_W-1:0] sel_changes;
  logic             clr;
`ifdef MUX2_4_PARITY_EN
  logic             par;
  logic             par_q;
`endif

  int n_cmp = 0;
  int n_err = 0;

  mux2_4 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .out         (out),
    .a           (a),
    .b           (b),
    .s           (s),
    .en          (en),
    .out_q       (out_q),
    .sel_changes (sel_changes),
    .clr         (clr)
`ifdef MUX2_4_PARITY_EN
    ,
    .par         (par),
    .par_q       (par_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             s;
    logic [WIDTH-1:0] exp_out;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{4'b0000, 4'b0000, 1'b0, 4'b0000};
    vecs[1] = '{4'b1100, 4'b0000, 1'b0, 4'b1100};
    vecs[2] = '{4'b0000, 4'b0110, 1'b0, 4'b0000};
    vecs[3] = '{4'b0000, 4'b0101, 1'b1, 4'b0101};
    vecs[4] = '{4'b1111, 4'b0000, 1'b1, 4'b0000};
    vecs[5] = '{4'b1010, 4'b0101, 1'b0, 4'b1010};
    vecs[6] = '{4'b1010, 4'b0101, 1'b1, 4'b0101};
    vecs[7] = '{4'b1001, 4'b1001, 1'b1, 4'b1001};

    rst_n = 1'b0;
    a = 4'b0000; b = 4'b0000; s = 1'b0; en = 1'b0; clr = 1'b0;
    #3;
    check("reset_out_q", 32'(out_q), 32'h0);
    check("reset_sel_changes", 32'(sel_changes), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Combinational path: result in the same step.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a = vecs[i].a; b = vecs[i].b; s = vecs[i].s;
      #1;
      check($sformatf("comb_out[%0d]", i), 32'(out), 32'(vecs[i].exp_out));
    end
    check("out_q_hold_en0", 32'(out_q), 32'h0);

    // Fresh reset, then first edge with s=1 counts against s_prev=0.
    @(negedge clk);
    rst_n = 1'b0;
    s = 1'b1; a = 4'b0000; b = 4'b0101; en = 1'b1;
    #1;
    check("rst_clears_cnt", 32'(sel_changes), 32'h0);
    rst_n = 1'b1;
    edge_settle();
    check("load_out_q", 32'(out_q), 32'h5);
    check("first_edge_count", 32'(sel_changes), 32'h1);

    @(negedge clk);
    en = 1'b0; b = 4'b1111;
    edge_settle();
    check("hold_out_q", 32'(out_q), 32'h5);
    check("out_follows_b", 32'(out), 32'hF);
    check("no_change_cnt", 32'(sel_changes), 32'h1);

    @(negedge clk); s = 1'b0;
    edge_settle();
    @(negedge clk); s = 1'b1;
    edge_settle();
    check("cnt_three", 32'(sel_changes), 32'h3);

    // Async reset between edges, with a pending load and increment.
    @(negedge clk);
    en = 1'b1; s = 1'b0; a = 4'b0011;
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_q", 32'(out_q), 32'h0);
    check("async_rst_cnt", 32'(sel_changes), 32'h0);
    check("async_rst_out", 32'(out), 32'h3);
    edge_settle();
    check("rst_held_out_q", 32'(out_q), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    edge_settle();
    check("post_rst_load_a", 32'(out_q), 32'h3);
    check("post_rst_s0_nocount", 32'(sel_changes), 32'h0);

    // Saturation after 300 toggles.
    en = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      s = ~s;
      edge_settle();
      if (i == 9) check("cnt_ten", 32'(sel_changes), 32'd10);
    end
    check("cnt_saturated", 32'(sel_changes), 32'd255);

    // clr wins over a simultaneous toggle.
    @(negedge clk);
    clr = 1'b1; s = ~s;
    edge_settle();
    check("clr_priority", 32'(sel_changes), 32'h0);
    @(negedge clk);
    clr = 1'b0; s = ~s;
    edge_settle();
    check("count_after_clr", 32'(sel_changes), 32'h1);

`ifdef MUX2_4_PARITY_EN
    @(negedge clk);
    s = 1'b1; b = 4'b0111; en = 1'b1;
    #1;
    check("par_0111", 32'(par), 32'h1);
    edge_settle();
    check("par_q_0111", 32'(par_q), 32'h1);
    @(negedge clk);
    b = 4'b0101;
    #1;
    check("par_0101", 32'(par), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
